rf_access_master: RTL and testbench

Command-driven sequencer that owns the initiator side of the processor's single-port 8×16 register-file interface (shared 3-bit address, load strobe, read-enable strobe, write data, combinational read data). It accepts READ/WRITE/MOVE/SWAP commands over a valid/ready channel. It serialises each command into legal one-port read and write cycles, and returns READ results over a valid/ready response channel. It sits between the control unit (or a debug/test host) and the register file.

---
 rtl/rf_access_master_if.sv | 55 +++++
 rtl/rf_access_master.sv | 123 ++++++++++++
 tb/tb_rf_access_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_master_if.sv
// Command, response and register-file port bundle for rf_access_master.
// master is the sequencer's view, slave is the host/register-file view.
interface rf_access_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_ra;
    logic [2:0]  cmd_rb;
    logic [15:0] cmd_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;
    logic [2:0]  rf_addr;
    logic        rf_we;
    logic        rf_re;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;

    modport master (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_ra,
        input  cmd_rb,
        input  cmd_imm,
        input  rsp_ready,
        input  rf_rdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output busy,
        output rf_addr,
        output rf_we,
        output rf_re,
        output rf_wdata
    );

    modport slave (
        output cmd_valid,
        output cmd_op,
        output cmd_ra,
        output cmd_rb,
        output cmd_imm,
        output rsp_ready,
        output rf_rdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  busy,
        input  rf_addr,
        input  rf_we,
        input  rf_re,
        input  rf_wdata
    );
endinterface

// File: rtl/rf_access_master.sv
// Serialises READ/WRITE/MOVE/SWAP commands onto a single-port 8x16
// register file; READ results leave through a valid/ready response.
module rf_access_master (
    input  logic               clk,
    input  logic               reset,
    rf_access_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        RSP
    } state_e;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [2:0]  ra_q;
    logic [2:0]  rb_q;
    logic [15:0] imm_q;
    logic [15:0] tmp_a_q;
    logic [15:0] tmp_b_q;
    logic        accept;

    assign accept = (state_q == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            ra_q    <= 3'd0;
            rb_q    <= 3'd0;
            imm_q   <= 16'h0;
            tmp_a_q <= 16'h0;
            tmp_b_q <= 16'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus.cmd_op;
                ra_q  <= bus.cmd_ra;
                rb_q  <= bus.cmd_rb;
                imm_q <= bus.cmd_imm;
            end
            if (state_q == RD_A) tmp_a_q <= bus.rf_rdata;
            if (state_q == RD_B) tmp_b_q <= bus.rf_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_WRITE) state_d = WR_A;
                    else                        state_d = RD_A;
                end
            end
            RD_A: begin
                if (op_q == OP_READ)      state_d = RSP;
                else if (op_q == OP_MOVE) state_d = WR_B;
                else                      state_d = RD_B;
            end
            RD_B: state_d = WR_A;
            WR_A: begin
                if (op_q == OP_WRITE) state_d = IDLE;
                else                  state_d = WR_B;
            end
            WR_B: state_d = IDLE;
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only; no input feeds through.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 16'h0;
        bus.rf_addr   = 3'd0;
        bus.rf_we     = 1'b0;
        bus.rf_re     = 1'b0;
        bus.rf_wdata  = 16'h0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            RD_A: begin
                bus.rf_addr = ra_q;
                bus.rf_re   = 1'b1;
            end
            RD_B: begin
                bus.rf_addr = rb_q;
                bus.rf_re   = 1'b1;
            end
            WR_A: begin
                bus.rf_addr  = ra_q;
                bus.rf_we    = 1'b1;
                bus.rf_wdata = (op_q == OP_WRITE) ? imm_q : tmp_b_q;
            end
            WR_B: begin
                bus.rf_addr  = rb_q;
                bus.rf_we    = 1'b1;
                bus.rf_wdata = tmp_a_q;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = tmp_a_q;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_rf_access_master.sv
// Randomised bench for rf_access_master: a register file plus a
// command-level reference model of register contents and step order.
module tb_rf_access_master;
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_MV = 2'b10;
    localparam logic [1:0] OP_SW = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    logic [15:0] rf_mem [0:7] = '{default: 16'h0};
    logic [15:0] ref_rf [0:7] = '{default: 16'h0};

    rf_access_master_if bus ();

    rf_access_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.rf_rdata = bus.rf_re ? rf_mem[bus.rf_addr] : 16'h0;

    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
    end

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [15:0] imm,
                           input int dly);
        logic [15:0] va, vb;
        int          n;
        logic        s_we [4];
        logic [2:0]  s_ad [4];
        logic [15:0] s_wd [4];
        va = ref_rf[ra];
        vb = ref_rf[rb];
        n  = 0;
        case (op)
            OP_RD: begin
                n = 1;
                s_we[0] = 0; s_ad[0] = ra; s_wd[0] = 0;
            end
            OP_WR: begin
                n = 1;
                s_we[0] = 1; s_ad[0] = ra; s_wd[0] = imm;
            end
            OP_MV: begin
                n = 2;
                s_we[0] = 0; s_ad[0] = ra; s_wd[0] = 0;
                s_we[1] = 1; s_ad[1] = rb; s_wd[1] = va;
            end
            default: begin
                n = 4;
                s_we[0] = 0; s_ad[0] = ra; s_wd[0] = 0;
                s_we[1] = 0; s_ad[1] = rb; s_wd[1] = 0;
                s_we[2] = 1; s_ad[2] = ra; s_wd[2] = vb;
                s_we[3] = 1; s_ad[3] = rb; s_wd[3] = va;
            end
        endcase
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        bus.cmd_imm   = imm;
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL accept: cmd_ready=%b busy=%b, need 1/0",
                     bus.cmd_ready, bus.busy);
        end
        @(negedge clk);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom);
        bus.cmd_ra    = 3'($urandom);
        bus.cmd_rb    = 3'($urandom);
        bus.cmd_imm   = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            vectors++;
            if (bus.rf_we !== s_we[i] || bus.rf_re !== !s_we[i] ||
                bus.rf_addr !== s_ad[i] ||
                (s_we[i] && bus.rf_wdata !== s_wd[i]) ||
                bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL step op=%0d i=%0d: we=%b re=%b a=%0d d=%h, need we=%b a=%0d d=%h",
                         op, i, bus.rf_we, bus.rf_re, bus.rf_addr,
                         bus.rf_wdata, s_we[i], s_ad[i], s_wd[i]);
            end
        end
        if (op == OP_RD) begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                bus.rsp_ready = (k == dly);
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== va ||
                    bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                    bus.rf_we !== 1'b0 || bus.rf_re !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp k=%0d: valid=%b data=%h rdy=%b, need 1 %h 0",
                             k, bus.rsp_valid, bus.rsp_data,
                             bus.cmd_ready, va);
                end
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            bus.rsp_valid !== 1'b0 || bus.rf_we !== 1'b0 ||
            bus.rf_re !== 1'b0) begin
            errors++;
            $display("FAIL done op=%0d: busy=%b rdy=%b valid=%b, need 0 1 0",
                     op, bus.busy, bus.cmd_ready, bus.rsp_valid);
        end
        case (op)
            OP_WR: ref_rf[ra] = imm;
            OP_MV: ref_rf[rb] = va;
            OP_SW: begin
                ref_rf[ra] = vb;
                ref_rf[rb] = va;
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WR;
        bus.cmd_ra    = 3'd7;
        bus.cmd_rb    = 3'd0;
        bus.cmd_imm   = 16'hDEAD;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_data !== 16'h0 || bus.busy !== 1'b0 ||
            bus.rf_addr !== 3'd0 || bus.rf_we !== 1'b0 ||
            bus.rf_re !== 1'b0 || bus.rf_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b we=%b re=%b addr=%0d, need 1 0 0 0 0",
                     bus.cmd_ready, bus.busy, bus.rf_we, bus.rf_re,
                     bus.rf_addr);
        end
        bus.cmd_valid = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || rf_mem[7] !== 16'h0) begin
            errors++;
            $display("FAIL reset_prio: busy=%b r7=%h, need 0 0000",
                     bus.busy, rf_mem[7]);
        end
    endtask

    task automatic test_write();
        run_cmd(OP_WR, 3'd3, 3'd6, 16'hBEEF, 0);
        vectors++;
        if (rf_mem[3] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_r3: got %h need BEEF", rf_mem[3]);
        end
        run_cmd(OP_RD, 3'd3, 3'd1, 16'h5555, 1);
    endtask

    task automatic test_read();
        run_cmd(OP_WR, 3'd5, 3'd0, 16'h1234, 0);
        run_cmd(OP_RD, 3'd5, 3'd2, 16'hFFFF, 4);
    endtask

    task automatic test_move();
        run_cmd(OP_WR, 3'd1, 3'd0, 16'h00AA, 0);
        run_cmd(OP_MV, 3'd1, 3'd6, 16'h9999, 0);
        vectors++;
        if (rf_mem[6] !== 16'h00AA || rf_mem[1] !== 16'h00AA) begin
            errors++;
            $display("FAIL move: r1=%h r6=%h need 00AA 00AA",
                     rf_mem[1], rf_mem[6]);
        end
        run_cmd(OP_MV, 3'd6, 3'd6, 16'h0, 0);
    endtask

    task automatic test_swap();
        run_cmd(OP_WR, 3'd2, 3'd0, 16'h1111, 0);
        run_cmd(OP_WR, 3'd4, 3'd0, 16'h2222, 0);
        run_cmd(OP_SW, 3'd2, 3'd4, 16'h0, 0);
        vectors++;
        if (rf_mem[2] !== 16'h2222 || rf_mem[4] !== 16'h1111) begin
            errors++;
            $display("FAIL swap: r2=%h r4=%h need 2222 1111",
                     rf_mem[2], rf_mem[4]);
        end
        run_cmd(OP_SW, 3'd2, 3'd2, 16'h0, 0);
        vectors++;
        if (rf_mem[2] !== 16'h2222) begin
            errors++;
            $display("FAIL swap_self: r2=%h need 2222", rf_mem[2]);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] va, vb;
        va = ref_rf[2];
        vb = ref_rf[4];
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SW;
        bus.cmd_ra    = 3'd2;
        bus.cmd_rb    = 3'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.rf_we !== 1'b1 || bus.rf_addr !== 3'd2 ||
            bus.rf_wdata !== vb) begin
            errors++;
            $display("FAIL wr_a: we=%b a=%0d d=%h need 1 2 %h",
                     bus.rf_we, bus.rf_addr, bus.rf_wdata, vb);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_rf[2] = vb;
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.rf_we !== 1'b0 || bus.rf_re !== 1'b0 ||
            bus.rf_addr !== 3'd0 || bus.rf_wdata !== 16'h0 ||
            bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort: rdy=%b busy=%b we=%b re=%b, need 1 0 0 0",
                     bus.cmd_ready, bus.busy, bus.rf_we, bus.rf_re);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus.rf_we !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: we=%b busy=%b need 0 0",
                         bus.rf_we, bus.busy);
            end
        end
        vectors++;
        if (rf_mem[4] !== vb || rf_mem[2] !== vb || va === 16'hx) begin
            errors++;
            $display("FAIL abort_regs: r2=%h r4=%h need %h %h",
                     rf_mem[2], rf_mem[4], vb, vb);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_RD;
        bus.cmd_ra    = 3'd4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0 ||
            bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_drop: valid=%b data=%h rdy=%b need 0 0000 1",
                     bus.rsp_valid, bus.rsp_data, bus.cmd_ready);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            run_cmd(2'($urandom), 3'($urandom), 3'($urandom),
                    16'($urandom), int'($urandom_range(0, 3)));
        end
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (rf_mem[r] !== ref_rf[r]) begin
                errors++;
                $display("FAIL regs r%0d: got %h need %h",
                         r, rf_mem[r], ref_rf[r]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rf_we === 1'b1 && bus.rf_re === 1'b1) begin
            vectors++;
            errors++;
            $display("FAIL we_re_overlap at %0t", $time);
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_ra    = 3'd0;
        bus.cmd_rb    = 3'd0;
        bus.cmd_imm   = 16'h0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_move();
        test_swap();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
